bram_port_arbiter: RTL and testbench

- Shares one single-port, read-first, 32-bit word-addressed block RAM between two requesters.
- Port 0 is the core load/store unit; port 1 is the UART program loader / debug DMA.
- Registers the arbitration decision, drives the RAM enable/write/address/data pins, and steers the 1-cycle-latency RAM output back to the granted requester with an ack.
- Sits between the memory stage and the existing data BRAM instance.

---
 rtl/mem_pkg.sv | 28 ++
 rtl/bram_port_arbiter_if.sv | 41 ++++
 rtl/bram_rr_pick.sv | 26 ++
 rtl/bram_port_arbiter.sv | 115 +++++++++++
 tb/tb_bram_port_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared memory-side definitions for the data BRAM arbiter.
//   DATA_W / ADDR_W : word and word-address widths.
//   DEPTH           : number of valid RAM words (0..DEPTH-1).
//   port_id_t       : requester id (PORT_CORE = load/store unit, PORT_LOADER = UART loader / debug DMA).
//   mem_req_t       : one requester's access payload.
package mem_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DEPTH  = 20001;

  typedef enum logic {
    PORT_CORE   = 1'b0,
    PORT_LOADER = 1'b1
  } port_id_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  // True when a word address falls inside a RAM of the given depth.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr, input int unsigned depth);
    return addr < ADDR_W'(depth);
  endfunction

endpackage

// File: rtl/bram_port_arbiter_if.sv
// Two-requester handshake bundle in front of the shared data BRAM.
//   reqN/weN/addrN/wdataN : request side, held stable until gntN.
//   gntN                  : combinational accept.
//   ackN/rdataN/errN      : response one cycle after the accept.
// master = requesters, slave = arbiter.
interface bram_port_arbiter_if;
  import mem_pkg::*;

  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              gnt0;
  logic              ack0;
  logic [DATA_W-1:0] rdata0;
  logic              err0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt1;
  logic              ack1;
  logic [DATA_W-1:0] rdata1;
  logic              err1;

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    input  gnt0, ack0, rdata0, err0,
    input  gnt1, ack1, rdata1, err1
  );

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    output gnt0, ack0, rdata0, err0,
    output gnt1, ack1, rdata1, err1
  );

endinterface

// File: rtl/bram_rr_pick.sv
// Two-way grant picker.
//   req      : {req1, req0}
//   last_gnt : port granted on the most recent accept
//   rr_en    : 1 = round-robin on a tie, 0 = port 0 always wins a tie
//   gnt      : one-hot grant, {gnt1, gnt0}, all zero when nothing requests
module bram_rr_pick
  import mem_pkg::*;
(
  input  logic [1:0] req,
  input  port_id_t   last_gnt,
  input  logic       rr_en,
  output logic [1:0] gnt
);

  // On a tie in round-robin mode the port that did not win last time goes first.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (rr_en && (last_gnt == PORT_CORE)) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one single-port, read-first, 1-cycle-latency data BRAM between the
// core load/store unit (port 0) and the UART loader / debug DMA (port 1).
// Issue is combinational from the grant; the response (ack/rdata/err) comes
// one cycle later from a small registered response pipeline.
//   clk, rstn            : clock, synchronous active-low reset
//   bus (slave)          : both requesters' req/we/addr/wdata, gnt/ack/rdata/err
//   ram_en/we/addr/di    : drive the external RAM
//   ram_dout             : RAM read data (valid the cycle after ram_en)
// Build option: define ADDR_CHECK_EN to block out-of-range accesses
// (addr >= DEPTH) and return them with err = 1; otherwise addresses pass
// through unchecked and err0/err1 are constant 0.
module bram_port_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH         = mem_pkg::DEPTH,
  parameter bit          RR_EN_DEFAULT = 1'b1
) (
  input  logic                clk,
  input  logic                rstn,
  bram_port_arbiter_if.slave  bus,
  output logic                ram_en,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_di,
  input  logic [DATA_W-1:0]   ram_dout
);

  if (DEPTH == 0) begin : g_bad_depth
    $error("bram_port_arbiter: DEPTH must be non-zero");
  end

  logic [1:0] pick;
  logic [1:0] gnt_c;
  logic       any_gnt;
  logic       oob;
  mem_req_t   req_p0;
  mem_req_t   req_p1;
  mem_req_t   win;

  port_id_t   last_gnt;
  port_id_t   last_gnt_nxt;
  logic       resp_vld;
  logic       resp_vld_nxt;
  port_id_t   resp_id;
  port_id_t   resp_id_nxt;
  logic       resp_err;
  logic       resp_err_nxt;

  bram_rr_pick u_pick (
    .req      ({bus.req1, bus.req0}),
    .last_gnt (last_gnt),
    .rr_en    (RR_EN_DEFAULT),
    .gnt      (pick)
  );

  // Nothing is accepted while reset is asserted.
  assign gnt_c    = pick & {2{rstn}};
  assign any_gnt  = |gnt_c;
  assign bus.gnt0 = gnt_c[0];
  assign bus.gnt1 = gnt_c[1];

  // Issue the winner's access straight to the RAM pins.
  always_comb begin
    req_p0 = '{we: bus.we0, addr: bus.addr0, wdata: bus.wdata0};
    req_p1 = '{we: bus.we1, addr: bus.addr1, wdata: bus.wdata1};
    win    = gnt_c[1] ? req_p1 : req_p0;
`ifdef ADDR_CHECK_EN
    oob    = any_gnt && !addr_in_range(win.addr, DEPTH);
`else
    oob    = 1'b0;
`endif
    // An out-of-range accept is still granted but never reaches the RAM.
    ram_en   = any_gnt & ~oob;
    ram_we   = any_gnt & ~oob & win.we;
    ram_addr = any_gnt ? win.addr  : '0;
    ram_di   = any_gnt ? win.wdata : '0;
  end

  // Next-state for the arbitration history and the response pipeline.
  always_comb begin
    last_gnt_nxt = last_gnt;
    resp_vld_nxt = any_gnt;
    resp_id_nxt  = port_id_t'(gnt_c[1]);
    resp_err_nxt = oob;
    if (any_gnt) begin
      last_gnt_nxt = port_id_t'(gnt_c[1]);
    end
  end

  // last_gnt resets to the loader so the core wins the first tie.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      last_gnt <= PORT_LOADER;
      resp_vld <= 1'b0;
      resp_id  <= PORT_CORE;
      resp_err <= 1'b0;
    end else begin
      last_gnt <= last_gnt_nxt;
      resp_vld <= resp_vld_nxt;
      resp_id  <= resp_id_nxt;
      resp_err <= resp_err_nxt;
    end
  end

  // Steer the RAM output to whichever port was accepted last cycle.
  always_comb begin
    bus.ack0   = resp_vld & (resp_id == PORT_CORE);
    bus.ack1   = resp_vld & (resp_id == PORT_LOADER);
    bus.err0   = bus.ack0 & resp_err;
    bus.err1   = bus.ack1 & resp_err;
    bus.rdata0 = (bus.ack0 & ~resp_err) ? ram_dout : '0;
    bus.rdata1 = (bus.ack1 & ~resp_err) ? ram_dout : '0;
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: one round-robin and one fixed-priority
// instance, each with its own read-first RAM, driven by directed sequences
// and then random traffic, checked against a cycle-level reference model.
module tb_bram_port_arbiter;
  import mem_pkg::*;

  localparam int unsigned NW = mem_pkg::DEPTH;
`ifdef ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  bram_port_arbiter_if bus_rr ();
  bram_port_arbiter_if bus_fx ();

  logic        rr_en, rr_we, fx_en, fx_we;
  logic [31:0] rr_addr, rr_di, fx_addr, fx_di;
  logic [31:0] rr_dout = '0;
  logic [31:0] fx_dout = '0;

  bram_port_arbiter #(.DEPTH(NW), .RR_EN_DEFAULT(1'b1)) u_rr (
    .clk(clk), .rstn(rstn), .bus(bus_rr),
    .ram_en(rr_en), .ram_we(rr_we), .ram_addr(rr_addr), .ram_di(rr_di), .ram_dout(rr_dout)
  );

  bram_port_arbiter #(.DEPTH(NW), .RR_EN_DEFAULT(1'b0)) u_fx (
    .clk(clk), .rstn(rstn), .bus(bus_fx),
    .ram_en(fx_en), .ram_we(fx_we), .ram_addr(fx_addr), .ram_di(fx_di), .ram_dout(fx_dout)
  );

  // Read-first single-port RAMs attached to each instance.
  logic [31:0] ram_rr [NW];
  logic [31:0] ram_fx [NW];

  always @(posedge clk) begin
    if (rr_en && rr_addr < NW) begin
      rr_dout <= ram_rr[rr_addr[14:0]];
      if (rr_we) ram_rr[rr_addr[14:0]] <= rr_di;
    end
    if (fx_en && fx_addr < NW) begin
      fx_dout <= ram_fx[fx_addr[14:0]];
      if (fx_we) ram_fx[fx_addr[14:0]] <= fx_di;
    end
  end

  // Stimulus, indexed [instance][port].
  logic        s_req [2][2];
  logic        s_we  [2][2];
  logic [31:0] s_addr[2][2];
  logic [31:0] s_wd  [2][2];

  assign bus_rr.req0 = s_req[0][0];  assign bus_rr.we0 = s_we[0][0];
  assign bus_rr.addr0 = s_addr[0][0]; assign bus_rr.wdata0 = s_wd[0][0];
  assign bus_rr.req1 = s_req[0][1];  assign bus_rr.we1 = s_we[0][1];
  assign bus_rr.addr1 = s_addr[0][1]; assign bus_rr.wdata1 = s_wd[0][1];
  assign bus_fx.req0 = s_req[1][0];  assign bus_fx.we0 = s_we[1][0];
  assign bus_fx.addr0 = s_addr[1][0]; assign bus_fx.wdata0 = s_wd[1][0];
  assign bus_fx.req1 = s_req[1][1];  assign bus_fx.we1 = s_we[1][1];
  assign bus_fx.addr1 = s_addr[1][1]; assign bus_fx.wdata1 = s_wd[1][1];

  // Observed outputs, indexed [instance].
  logic [1:0]  o_gnt[2], o_ack[2], o_err[2];
  logic        o_en [2];
  logic [31:0] o_rd [2][2];

  assign o_gnt[0] = {bus_rr.gnt1, bus_rr.gnt0};
  assign o_ack[0] = {bus_rr.ack1, bus_rr.ack0};
  assign o_err[0] = {bus_rr.err1, bus_rr.err0};
  assign o_en[0]  = rr_en;
  assign o_rd[0][0] = bus_rr.rdata0;
  assign o_rd[0][1] = bus_rr.rdata1;
  assign o_gnt[1] = {bus_fx.gnt1, bus_fx.gnt0};
  assign o_ack[1] = {bus_fx.ack1, bus_fx.ack0};
  assign o_err[1] = {bus_fx.err1, bus_fx.err0};
  assign o_en[1]  = fx_en;
  assign o_rd[1][0] = bus_fx.rdata0;
  assign o_rd[1][1] = bus_fx.rdata1;

  // Reference model state.
  logic [31:0] refm [2][NW];
  int          last_w [2];
  bit          ev     [2];
  int          eid    [2];
  bit          eerr   [2];
  logic [31:0] erd    [2];
  int          win    [2];
  bit          woob   [2];
  bit          seen   [2][2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic string dn(input int d);
    return (d == 0) ? "rr" : "fx";
  endfunction

  function automatic bit is_oob(input logic [31:0] a);
    return CHK && (a >= NW);
  endfunction

  task automatic setp(input int d, input int p, input bit r, input bit we,
                      input logic [31:0] a, input logic [31:0] wd);
    s_req[d][p] = r; s_we[d][p] = we; s_addr[d][p] = a; s_wd[d][p] = wd;
  endtask

  task automatic setb(input int p, input bit r, input bit we,
                      input logic [31:0] a, input logic [31:0] wd);
    for (int d = 0; d < 2; d++) setp(d, p, r, we, a, wd);
  endtask

  task automatic idle();
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) setp(d, p, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Decide this cycle's winner from the rules and compare all outputs.
  task automatic settle();
    #1;
    for (int d = 0; d < 2; d++) begin
      int w;
      bit r0, r1;
      logic [31:0] eg, ea, ee, e0, e1;
      r0 = s_req[d][0] && rstn;
      r1 = s_req[d][1] && rstn;
      if (r0 && r1)  w = (d == 0 && last_w[d] == 0) ? 1 : 0;
      else if (r0)   w = 0;
      else if (r1)   w = 1;
      else           w = -1;
      win[d]  = w;
      woob[d] = (w >= 0) && is_oob(s_addr[d][w]);
      eg = (w < 0) ? 32'd0 : (32'd1 << w);
      ea = ev[d] ? (32'd1 << eid[d]) : 32'd0;
      ee = (ev[d] && eerr[d]) ? (32'd1 << eid[d]) : 32'd0;
      e0 = (ev[d] && eid[d] == 0) ? erd[d] : 32'd0;
      e1 = (ev[d] && eid[d] == 1) ? erd[d] : 32'd0;
      check({dn(d), "_gnt"},    32'(o_gnt[d]), eg);
      check({dn(d), "_ram_en"}, 32'(o_en[d]), 32'((w >= 0) && !woob[d]));
      check({dn(d), "_ack"},    32'(o_ack[d]), ea);
      check({dn(d), "_err"},    32'(o_err[d]), ee);
      check({dn(d), "_rdata0"}, o_rd[d][0], e0);
      check({dn(d), "_rdata1"}, o_rd[d][1], e1);
    end
  endtask

  // Commit the accepted access to the model, then move to the next cycle.
  task automatic advance();
    for (int d = 0; d < 2; d++) begin
      int w;
      w = win[d];
      if (!rstn) begin
        ev[d] = 1'b0;
        last_w[d] = 1;
      end else if (w < 0) begin
        ev[d] = 1'b0;
      end else begin
        ev[d]   = 1'b1;
        eid[d]  = w;
        eerr[d] = woob[d];
        erd[d]  = woob[d] ? 32'd0 : refm[d][s_addr[d][w][14:0]];
        if (s_we[d][w] && !woob[d]) refm[d][s_addr[d][w][14:0]] = s_wd[d][w];
        last_w[d] = w;
      end
      seen[d][0] = (w == 0);
      seen[d][1] = (w == 1);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < int'(NW); i++) begin
      logic [31:0] v;
      v = $urandom;
      ram_rr[i] = v; ram_fx[i] = v; refm[0][i] = v; refm[1][i] = v;
    end
    for (int d = 0; d < 2; d++) begin
      last_w[d] = 1; ev[d] = 1'b0; eid[d] = 0; eerr[d] = 1'b0; erd[d] = '0;
      win[d] = -1; woob[d] = 1'b0; seen[d][0] = 1'b0; seen[d][1] = 1'b0;
    end
    idle();
    rstn = 1'b0;
    @(negedge clk);

    // Reset with both ports requesting: nothing issues.
    setb(0, 1'b1, 1'b0, 32'd0, 32'd0);
    setb(1, 1'b1, 1'b0, 32'd1, 32'd0);
    repeat (2) begin
      settle();
      for (int d = 0; d < 2; d++) begin
        check({dn(d), "_rst_gnt"}, 32'(o_gnt[d]), 32'd0);
        check({dn(d), "_rst_en"},  32'(o_en[d]),  32'd0);
        check({dn(d), "_rst_ack"}, 32'(o_ack[d]), 32'd0);
      end
      advance();
    end

    // First tie after reset goes to port 0.
    rstn = 1'b1;
    settle();
    for (int d = 0; d < 2; d++) check({dn(d), "_first_tie"}, 32'(o_gnt[d]), 32'd1);
    advance();
    idle(); settle(); advance();

    // Write through port 0, read back through port 1.
    setb(0, 1'b1, 1'b1, 32'd5, 32'hDEADBEEF);
    settle(); advance();
    idle();
    setb(1, 1'b1, 1'b0, 32'd5, 32'd0);
    settle();
    for (int d = 0; d < 2; d++) check({dn(d), "_rd_gnt1"}, 32'(o_gnt[d]), 32'd2);
    advance();
    idle(); settle();
    for (int d = 0; d < 2; d++) begin
      check({dn(d), "_rd_ack"},   32'(o_ack[d]), 32'd2);
      check({dn(d), "_rd_data1"}, o_rd[d][1], 32'hDEADBEEF);
    end
    advance();

    // Sustained contention: alternating in RR, port 0 only in fixed.
    setb(0, 1'b1, 1'b0, 32'd10, 32'd0);
    setb(1, 1'b1, 1'b0, 32'd11, 32'd0);
    for (int i = 0; i < 4; i++) begin
      settle();
      check("rr_contend_gnt", 32'(o_gnt[0]), (i % 2 == 0) ? 32'd1 : 32'd2);
      check("fx_contend_gnt", 32'(o_gnt[1]), 32'd1);
      advance();
    end
    setb(0, 1'b0, 1'b0, 32'd0, 32'd0);
    settle();
    for (int d = 0; d < 2; d++) check({dn(d), "_drop0_gnt"}, 32'(o_gnt[d]), 32'd2);
    advance();
    idle(); settle(); advance();

    // Read-first: a write returns the previous word.
    setb(0, 1'b1, 1'b1, 32'd7, 32'h11);
    settle(); advance();
    setb(0, 1'b1, 1'b1, 32'd7, 32'h22);
    settle(); advance();
    idle(); settle();
    for (int d = 0; d < 2; d++) check({dn(d), "_rf_old"}, o_rd[d][0], 32'h11);
    advance();
    setb(0, 1'b1, 1'b0, 32'd7, 32'd0);
    settle(); advance();
    idle(); settle();
    for (int d = 0; d < 2; d++) check({dn(d), "_rf_new"}, o_rd[d][0], 32'h22);
    advance();

`ifdef ADDR_CHECK_EN
    // Out-of-range write is blocked and flagged; last valid word is normal.
    setb(0, 1'b1, 1'b1, NW, 32'h55);
    settle();
    for (int d = 0; d < 2; d++) check({dn(d), "_oob_en"}, 32'(o_en[d]), 32'd0);
    advance();
    setb(0, 1'b1, 1'b0, NW - 1, 32'd0);
    settle();
    for (int d = 0; d < 2; d++) begin
      check({dn(d), "_oob_ack"},   32'(o_ack[d]), 32'd1);
      check({dn(d), "_oob_err"},   32'(o_err[d]), 32'd1);
      check({dn(d), "_oob_rdata"}, o_rd[d][0], 32'd0);
    end
    advance();
    idle(); settle();
    for (int d = 0; d < 2; d++) check({dn(d), "_last_err"}, 32'(o_err[d]), 32'd0);
    advance();
`endif

    // Random traffic with occasional abandoned requests and a mid-run reset.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rstn = ((cyc % 700) != 350);
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < 2; p++) begin
          if (!s_req[d][p] || seen[d][p]) begin
            logic [31:0] a;
            if ($urandom_range(0, 3) == 0) a = $urandom_range(0, NW - 1);
            else                           a = $urandom_range(0, 15);
            if (CHK && $urandom_range(0, 19) == 0) a = NW + $urandom_range(0, 7);
            setp(d, p, $urandom_range(0, 9) < 7, 1'($urandom), a, $urandom);
          end else if ($urandom_range(0, 19) == 0) begin
            s_req[d][p] = 1'b0;
          end
        end
      end
      settle();
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
